// File: rtl/uc_multiciclo.sv
// uc_multiciclo -- multicycle RV32I control unit.
// Sequences FETCH / DECODE / EXEC / MEM / WB over a shared memory port
// that uses a req/ready handshake. Memory waits are bounded by MEM_TIMEOUT.
// Retired instructions are counted in instret.
// Optional feature macro: UC_ILLEGAL_TRAP_EN. When it is defined, an unknown
// opcode traps. When it is undefined, an unknown opcode retires as a NOP.
module uc_multiciclo #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       selector,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             Less,
    input  logic             LessU,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ImmSel,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOP,
    output logic [1:0]       WDSrc,
    output logic             RegWriteEn,
    output logic [2:0]       state,
    output logic [RET_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    state_t            state_reg;
    logic [4:0]        opc_reg;
    logic [2:0]        f3_reg;
    logic [2:0]        imm_sel_reg;
    logic [1:0]        wd_src_reg;
    logic [WC_W-1:0]   wait_cnt_reg;
    logic [RET_W-1:0]  instret_reg;
    logic [1:0]        trap_cause_reg;
    logic              wait_expired;
    logic              branch_taken;

    function automatic logic is_known(input logic [4:0] s);
        case (s)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: is_known = 1'b1;
            default:                                is_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_fmt(input logic [4:0] s);
        case (s)
            OPC_STORE:            imm_fmt = 3'b001;
            OPC_BRANCH:           imm_fmt = 3'b010;
            OPC_JAL:              imm_fmt = 3'b011;
            OPC_LUI, OPC_AUIPC:   imm_fmt = 3'b100;
            default:              imm_fmt = 3'b000;
        endcase
    endfunction

    // Write-back source; a load's 01 only matters in WB, where it is used
    function automatic logic [1:0] wd_fmt(input logic [4:0] s);
        case (s)
            OPC_LOAD:             wd_fmt = 2'b01;
            OPC_JAL, OPC_JALR:    wd_fmt = 2'b10;
            OPC_LUI:              wd_fmt = 2'b11;
            default:              wd_fmt = 2'b00;
        endcase
    endfunction

    // The last permitted waiting cycle: a miss here ends in TRAP
    assign wait_expired = (wait_cnt_reg == WC_W'(MEM_TIMEOUT - 1));

    // Branch resolution from the same-cycle ALU flags
    always_comb begin
        branch_taken = 1'b0;
        case (f3_reg)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = ~Zero;
            3'b100:  branch_taken = Less;
            3'b101:  branch_taken = ~Less;
            3'b110:  branch_taken = LessU;
            3'b111:  branch_taken = ~LessU;
            default: branch_taken = 1'b0;
        endcase
    end

    // State sequencing, decode latching, wait counter, retire counter, trap cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            opc_reg        <= '0;
            f3_reg         <= '0;
            imm_sel_reg    <= '0;
            wd_src_reg     <= '0;
            wait_cnt_reg   <= '0;
            instret_reg    <= '0;
            trap_cause_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg    <= S_FETCH;
                    wait_cnt_reg <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (wait_expired) begin
                        state_reg      <= S_TRAP;
                        trap_cause_reg <= 2'b10;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
                    end
                end
                S_DECODE: begin
                    opc_reg     <= selector;
                    f3_reg      <= funct3;
                    imm_sel_reg <= imm_fmt(selector);
                    wd_src_reg  <= wd_fmt(selector);
                    if (is_known(selector)) begin
                        state_reg <= S_EXEC;
                    end else begin
`ifdef UC_ILLEGAL_TRAP_EN
                        state_reg      <= S_TRAP;
                        trap_cause_reg <= 2'b01;
`else
                        // Unknown opcode: PC already advanced, retire as a NOP
                        state_reg    <= S_FETCH;
                        wait_cnt_reg <= '0;
                        instret_reg  <= instret_reg + RET_W'(1);
`endif
                    end
                end
                S_EXEC: begin
                    case (opc_reg)
                        OPC_LOAD, OPC_STORE: begin
                            state_reg    <= S_MEM;
                            wait_cnt_reg <= '0;
                        end
                        OPC_BRANCH: begin
                            state_reg    <= S_FETCH;
                            wait_cnt_reg <= '0;
                            instret_reg  <= instret_reg + RET_W'(1);
                        end
                        default: state_reg <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opc_reg == OPC_STORE) begin
                            state_reg    <= S_FETCH;
                            wait_cnt_reg <= '0;
                            instret_reg  <= instret_reg + RET_W'(1);
                        end else begin
                            state_reg <= S_WB;
                        end
                    end else if (wait_expired) begin
                        state_reg      <= S_TRAP;
                        trap_cause_reg <= 2'b10;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
                    end
                end
                S_WB: begin
                    state_reg    <= S_FETCH;
                    wait_cnt_reg <= '0;
                    instret_reg  <= instret_reg + RET_W'(1);
                end
                S_TRAP: state_reg <= S_TRAP;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Control outputs decoded from the current state and latched decode info
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 2'b00;
        ImmSel     = 3'b000;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOP      = 2'b00;
        WDSrc      = 2'b00;
        RegWriteEn = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ImmSel = imm_fmt(selector);
                WDSrc  = wd_fmt(selector);
            end
            S_EXEC: begin
                ImmSel = imm_sel_reg;
                WDSrc  = wd_src_reg;
                case (opc_reg)
                    OPC_OP:    ALUOP = 2'b10;
                    OPC_OPIMM: begin
                        ALUSrcB = 2'b01;
                        ALUOP   = 2'b10;
                    end
                    OPC_LOAD, OPC_STORE: ALUSrcB = 2'b01;
                    OPC_BRANCH: begin
                        ALUOP   = 2'b01;
                        PCWrite = branch_taken;
                        PCSrc   = branch_taken ? 2'b01 : 2'b00;
                    end
                    OPC_AUIPC: begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b01;
                    end
                    OPC_JAL: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b01;
                    end
                    OPC_JALR: begin
                        ALUSrcB = 2'b01;
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ImmSel   = imm_sel_reg;
                WDSrc    = wd_src_reg;
                mem_req  = 1'b1;
                MemWrite = (opc_reg == OPC_STORE);
            end
            S_WB: begin
                ImmSel     = imm_sel_reg;
                WDSrc      = wd_src_reg;
                RegWriteEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = state_reg;
    assign instret    = instret_reg;
    assign trap       = (state_reg == S_TRAP);
    assign trap_cause = trap_cause_reg;

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle successor to the single-cycle RV32I control unit. Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It drives a shared instruction/data memory port through a req/ready handshake and resolves all six RV32I branch conditions from ALU flags. It adds R-type, AUIPC and JALR support, a memory-timeout trap and a retired-instruction counter. It sits between the instruction register (opcode bits [6:2] and funct3) and the multicycle datapath muxes.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum cycles a memory request is held waiting for mem_ready; legal range ≥1.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- selector  in  5  instr[6:2].
- funct3  in  3  instr[14:12].
- Zero  in  1  ALU result == 0.
- Less  in  1  signed rs1 < rs2.
- LessU  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- MemWrite  out  1  request is a store.
- IRWrite  out  1  load the instruction register (and OldPC).
- PCWrite  out  1  update the PC this cycle.
- PCSrc  out  2  PC source: 00 = PC+4, 01 = OldPC+imm, 10 = ALU result with bit0 cleared.
- ImmSel  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUSrcA  out  2  ALU A operand: 00 = rs1, 01 = OldPC, 10 = PC.
- ALUSrcB  out  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4.
- ALUOP  out  2  ALU operation: 00 = add, 01 = compare, 10 = funct-decoded.
- WDSrc  out  2  register write-data source: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = imm.
- RegWriteEn  out  1  register file write enable.
- state  out  3  current FSM state.
- instret  out  RET_W  count of retired instructions.
- trap  out  1  FSM is halted in TRAP.
- trap_cause  out  2  trap reason: 01 = illegal opcode, 10 = memory timeout.

## Operation
- States:
  - IDLE = 0: unconditionally → FETCH.
  - FETCH = 1: mem_req = 1, ALUSrcA = 10, ALUSrcB = 10. On mem_ready: IRWrite = 1, PCWrite = 1, PCSrc = 00 → DECODE.
  - DECODE = 2: ImmSel is set from selector → EXEC. Unknown selector: see Configuration.
  - EXEC = 3, by selector:
    - 01100 (OP): A = rs1, B = rs2, ALUOP = 10 → WB.
    - 00100 (OP-IMM): A = rs1, B = imm, ALUOP = 10 → WB.
    - 00000 (LOAD) and 01000 (STORE): A = rs1, B = imm, add → MEM.
    - 11000 (BRANCH): ALUOP = 01. Taken per funct3: 000 = Zero, 001 = !Zero, 100 = Less, 101 = !Less, 110 = LessU, 111 = !LessU; 010 and 011 are never taken. If taken, PCWrite = 1 and PCSrc = 01. Retires → FETCH.
    - 01101 (LUI): → WB with WDSrc = 11.
    - 00101 (AUIPC): A = OldPC, B = imm, add → WB.
    - 11011 (JAL): PCWrite = 1, PCSrc = 01 → WB with WDSrc = 10.
    - 11001 (JALR): A = rs1, B = imm, add; PCWrite = 1, PCSrc = 10 → WB with WDSrc = 10.
  - MEM = 4: mem_req = 1; MemWrite = 1 for a store. On mem_ready: a load → WB; a store retires → FETCH.
  - WB = 5: RegWriteEn = 1 for exactly one cycle; WDSrc = 01 for a load, otherwise as set in EXEC. Retires → FETCH.
  - TRAP = 7: all control outputs 0; trap = 1. Held until rst.
- ImmSel and WDSrc are held at their decoded values from DECODE through WB. All unlisted outputs are 0 in every state.
- Retire: instret increments by 1 on the edge that leaves the retiring state. It wraps modulo 2^RET_W.
- Timeout: wait_cnt clears on entry to FETCH or MEM and increments each cycle in which mem_req = 1 and mem_ready = 0. If wait_cnt == MEM_TIMEOUT−1 and mem_ready = 0, the FSM → TRAP with trap_cause = 10.
- Reset, at any point including mid-request: state = IDLE; all outputs 0; instret = 0; trap = 0; trap_cause = 00; wait_cnt = 0.

## Timing
- All outputs are Moore and registered-state decoded; they depend only on state plus the latched decode information. The exceptions are:
  - IRWrite, PCWrite and the FETCH/MEM exits, which are qualified by the same-cycle mem_ready.
  - The EXEC branch decision, which uses same-cycle flags.
- mem_req stays high until mem_ready is seen. A mem_ready seen in the MEM_TIMEOUT-th waiting cycle is accepted, not trapped.
- Latency from FETCH entry with zero-wait memory:
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ready while mem_req = 0 is ignored.

## Configuration
- UC_ILLEGAL_TRAP_EN defined: an unknown selector in DECODE → TRAP with trap_cause = 01; the instruction is not retired.
- UC_ILLEGAL_TRAP_EN undefined: an unknown selector is a NOP. DECODE → FETCH, and the instruction retires (PC was already advanced in FETCH).

## Test plan
- Reset, then ADDI (selector 00100) with mem_ready tied to 1 → states 0, 1, 2, 3, 5, 1; RegWriteEn is high only in cycle 5; instret = 1.
- BNE (funct3 001) with Zero = 0 → PCWrite = 1 and PCSrc = 01 in EXEC. Repeat with Zero = 1 → PCWrite = 0. Both return to FETCH; instret increments by 2 over the pair.
- LOAD with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles; WB has WDSrc = 01; total latency 8 cycles.
- MEM_TIMEOUT = 4 and mem_ready held at 0 in FETCH → TRAP after exactly 4 request cycles; trap = 1; trap_cause = 10; mem_req = 0 thereafter.
- Selector 11111: with UC_ILLEGAL_TRAP_EN defined → TRAP, trap_cause = 01, instret unchanged. Without it → back to FETCH, instret + 1.
- rst asserted mid-MEM store → MemWrite and mem_req drop immediately; state = 0 and instret = 0; FETCH re-enters one cycle after rst falls.
